// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer: per-channel sync, debounce and hold/long/repeat event generation
module multi_button_debouncer #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] button_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_long,
  output logic [NUM_CH-1:0] btn_repeat
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int LMAX = (LONG_CYCLES > 2) ? LONG_CYCLES : 2;
  localparam int HMAX = (REPEAT_CYCLES > LMAX) ? REPEAT_CYCLES : LMAX;
  localparam int HW   = $clog2(HMAX);
  typedef enum logic [1:0] {IDLE, HOLD, LONG} state_e;
  logic [NUM_CH-1:0] raw;
  assign raw = ACTIVE_LOW ? ~button_in : button_in;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic          s1_q, s2_q, level_q, press_q, rel_q, long_q, rep_q, acc;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q;
    state_e        state_q;
    // acc marks the edge where a changed, stable input is accepted
    always_comb begin
      acc    = (s2_q != level_q) && (dcnt_q == DW'(DEBOUNCE_CYCLES - 1));
      dcnt_d = (s2_q == level_q || acc) ? '0 : dcnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        dcnt_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
        hcnt_q  <= '0;
        state_q <= IDLE;
      end else begin
        s1_q    <= raw[c];
        s2_q    <= s1_q;
        dcnt_q  <= dcnt_d;
        level_q <= acc ? s2_q : level_q;
        press_q <= acc & s2_q;
        rel_q   <= acc & ~s2_q;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
        // a release overrides any terminal count landing on the same edge
        if (acc && !s2_q) begin
          state_q <= IDLE;
          hcnt_q  <= '0;
        end else begin
          case (state_q)
            IDLE: if (acc) begin
              state_q <= HOLD;
              hcnt_q  <= '0;
            end
            HOLD: if (hcnt_q == HW'(LONG_CYCLES - 1)) begin
              long_q  <= 1'b1;
              hcnt_q  <= '0;
              state_q <= LONG;
            end else hcnt_q <= hcnt_q + 1'b1;
            LONG: if (REPEAT_CYCLES > 0) begin
              if (hcnt_q == HW'(REPEAT_CYCLES - 1)) begin
                rep_q  <= 1'b1;
                hcnt_q <= '0;
              end else hcnt_q <= hcnt_q + 1'b1;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
    assign btn_level[c]   = level_q;
    assign btn_press[c]   = press_q;
    assign btn_release[c] = rel_q;
    assign btn_long[c]    = long_q;
    assign btn_repeat[c]  = rep_q;
  end
endmodule

// File: tb/tb_multi_button_debouncer.sv
// tb_multi_button_debouncer: directed checks of debounce, hold events and reset on three builds
module tb_multi_button_debouncer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] btn;
  logic       al_in;
  logic [1:0] m_lv, m_pr, m_rl, m_lg, m_rp;
  logic       n_lv, n_pr, n_rl, n_lg, n_rp;
  logic       a_lv, a_pr, a_rl, a_lg, a_rp;
  logic [3:0] lv, pr, rl, lg, rp;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         np[4]  = '{default: 0};
  int         tp[4]  = '{default: 0};
  int         nrl[4] = '{default: 0};
  int         trl[4] = '{default: 0};
  int         nl[4]  = '{default: 0};
  int         tl[4]  = '{default: 0};
  int         nrp[4] = '{default: 0};
  int         trp[4] = '{default: 0};
  int         e0, f0, snap;
  logic [15:0] pat;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign al_in = ~btn[0];
  assign lv = {a_lv, n_lv, m_lv};
  assign pr = {a_pr, n_pr, m_pr};
  assign rl = {a_rl, n_rl, m_rl};
  assign lg = {a_lg, n_lg, m_lg};
  assign rp = {a_rp, n_rp, m_rp};
  // index 0/1: main channels, 2: no-repeat build, 3: active-low build
  multi_button_debouncer #(.NUM_CH(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10),
    .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .button_in(btn), .btn_level(m_lv), .btn_press(m_pr),
    .btn_release(m_rl), .btn_long(m_lg), .btn_repeat(m_rp));
  multi_button_debouncer #(.NUM_CH(1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10),
    .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b0)) dut_nr (
    .clk(clk), .reset_n(reset_n), .button_in(btn[0]), .btn_level(n_lv), .btn_press(n_pr),
    .btn_release(n_rl), .btn_long(n_lg), .btn_repeat(n_rp));
  multi_button_debouncer #(.NUM_CH(1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10),
    .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset_n(reset_n), .button_in(al_in), .btn_level(a_lv), .btn_press(a_pr),
    .btn_release(a_rl), .btn_long(a_lg), .btn_repeat(a_rp));
  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      if (pr[i]) begin np[i]++;  tp[i]  = cyc; end
      if (rl[i]) begin nrl[i]++; trl[i] = cyc; end
      if (lg[i]) begin nl[i]++;  tl[i]  = cyc; end
      if (rp[i]) begin nrp[i]++; trp[i] = cyc; end
    end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    reset_n = 1'b0;
    btn = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", int'(lv), 0);
    chk("rst_press", int'(pr), 0);
    chk("rst_release", int'(rl), 0);
    chk("rst_long", int'(lg), 0);
    chk("rst_repeat", int'(rp), 0);
    reset_n = 1'b1;
    wait_to(cyc + 3);
    pat = 16'h7777;
    for (int i = 0; i < 16; i++) begin
      btn[0] = pat[i];
      @(posedge clk);
      #1;
    end
    btn[0] = 1'b0;
    wait_to(cyc + 10);
    chk("bounce_no_press", np[0], 0);
    chk("bounce_level", int'(lv[0]), 0);
    chk("bounce_no_press_al", np[3], 0);
    btn[0] = 1'b1;
    e0 = cyc + 1;
    wait_to(e0 + 7);
    chk("press_edge", tp[0], e0 + 5);
    chk("press_one_cycle", np[0], 1);
    chk("press_level", int'(lv[0]), 1);
    chk("press_ch1_quiet", np[1] + int'(lv[1]), 0);
    chk("press_edge_al", tp[3], e0 + 5);
    wait_to(e0 + 19);
    chk("long_edge", tl[0], e0 + 15);
    chk("long_count", nl[0], 1);
    chk("repeat1_edge", trp[0], e0 + 18);
    chk("repeat1_count", nrp[0], 1);
    chk("long_edge_nr", tl[2], e0 + 15);
    wait_to(e0 + 25);
    chk("repeat3_count", nrp[0], 3);
    chk("repeat3_edge", trp[0], e0 + 24);
    chk("nr_no_repeat", nrp[2], 0);
    chk("nr_long_once", nl[2], 1);
    chk("al_repeat3_count", nrp[3], 3);
    btn[0] = 1'b0;
    f0 = cyc + 1;
    wait_to(f0 + 7);
    chk("release_edge", trl[0], f0 + 5);
    chk("release_count", nrl[0], 1);
    chk("release_level", int'(lv[0]), 0);
    chk("release_edge_al", trl[3], f0 + 5);
    snap = nrp[0];
    wait_to(f0 + 17);
    chk("repeat_stopped", nrp[0], snap);
    btn = 2'b11;
    e0 = cyc + 1;
    wait_to(e0 + 6);
    chk("dual_press_ch0", tp[0], e0 + 5);
    chk("dual_press_ch1", tp[1], e0 + 5);
    btn[1] = 1'b0;
    wait_to(e0 + 17);
    chk("dual_release_ch1_edge", trl[1], e0 + 12);
    chk("dual_release_ch1_count", nrl[1], 1);
    chk("dual_ch0_not_released", nrl[0], 1);
    chk("dual_ch0_long", tl[0], e0 + 15);
    chk("dual_ch1_no_long", nl[1], 0);
    btn = 2'b00;
    wait_to(cyc + 12);
    btn[0] = 1'b1;
    e0 = cyc + 1;
    wait_to(e0 + 17);
    chk("pre_reset_long", tl[0], e0 + 15);
    snap = nrl[0];
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_level", int'(lv), 0);
    chk("async_rst_events", int'(pr | rl | lg | rp), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    e0 = cyc + 1;
    wait_to(e0 + 7);
    chk("post_reset_press", tp[0], e0 + 5);
    chk("post_reset_no_release", nrl[0], snap);
    chk("post_reset_press_al", tp[3], e0 + 5);
    chk("post_reset_press_nr", tp[2], e0 + 5);
    btn = 2'b00;
    wait_to(cyc + 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
